// File: rtl/execute_cc_mul.sv
// Y86 execute stage with registered condition codes and an optional iterative mulq.
// Define EXECUTE_MULQ_EN to build the shift-add multiplier FSM; otherwise mulq is an invalid OPq.
module execute_cc_mul #(
  parameter int XLEN   = 64,
  parameter int STAT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               E_icode,
  input  logic [3:0]               E_ifun,
  input  logic signed [XLEN-1:0]   E_ValA,
  input  logic signed [XLEN-1:0]   E_ValB,
  input  logic signed [XLEN-1:0]   E_ValC,
  input  logic [3:0]               E_dstE,
  input  logic [STAT_W-1:0]        m_stat,
  input  logic [STAT_W-1:0]        W_stat,
  output logic signed [XLEN-1:0]   e_ValE,
  output logic                     e_Cnd,
  output logic [3:0]               e_dstE,
  output logic                     ZF,
  output logic                     SF,
  output logic                     OF,
  output logic                     e_busy
);

  localparam logic signed [XLEN-1:0] EIGHT = XLEN'(8);

  function automatic logic is_exc(input logic [STAT_W-1:0] s);
    return (s == STAT_W'(2)) || (s == STAT_W'(3)) || (s == STAT_W'(4));
  endfunction

  function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s == b_s) && (r_s != a_s);
  endfunction

  function automatic logic sub_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s != b_s) && (r_s != b_s);
  endfunction

  logic                   exc;
  logic                   mul_done;
  logic                   mul_hold;
  logic [XLEN-1:0]        mul_res;
  logic                   mul_a_s;
  logic                   mul_b_s;
  logic                   cc_ld;
  logic                   ovf;
  logic                   cond;

  assign exc = is_exc(m_stat) | is_exc(W_stat);

`ifdef EXECUTE_MULQ_EN
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [XLEN-1:0]    acc;
  logic [XLEN-1:0]    mcand;
  logic [XLEN-1:0]    mplier;
  logic               mul_issue;

  assign mul_issue = (state == S_IDLE) && (E_icode == 4'h6) && (E_ifun == 4'h4);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mul_issue) state_nxt = S_MUL;
      S_MUL:   if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    e_busy   = mul_issue || (state == S_MUL);
    mul_hold = (state == S_MUL);
    mul_done = (state == S_DONE);
  end

  // Shift-add over XLEN bits; the low half of a two's-complement product needs no sign fix-up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (mul_issue) begin
      mcand   <= E_ValA;
      mplier  <= E_ValB;
      mul_a_s <= E_ValA[XLEN-1];
      mul_b_s <= E_ValB[XLEN-1];
      acc     <= '0;
      cnt     <= CNT_W'(XLEN);
    end else if (state == S_MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  assign mul_res = acc;
`else
  assign e_busy   = 1'b0;
  assign mul_hold = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_a_s  = 1'b0;
  assign mul_b_s  = 1'b0;
`endif

  // Result mux; a finished multiply owns the result regardless of what E currently shows.
  always_comb begin
    e_ValE = '0;
    cc_ld  = 1'b0;
    ovf    = 1'b0;
    if (mul_done) begin
      e_ValE = $signed(mul_res);
      cc_ld  = 1'b1;
      ovf    = add_ovf(mul_a_s, mul_b_s, mul_res[XLEN-1]);
    end else begin
      case (E_icode)
        4'h2:        e_ValE = E_ValA;
        4'h3:        e_ValE = E_ValC;
        4'h4, 4'h5:  e_ValE = E_ValB + E_ValC;
        4'h8, 4'hA:  e_ValE = E_ValB - EIGHT;
        4'h9, 4'hB:  e_ValE = E_ValB + EIGHT;
        4'h6: begin
          case (E_ifun)
            4'h0: begin
              e_ValE = E_ValB + E_ValA;
              cc_ld  = !mul_hold;
              ovf    = add_ovf(E_ValA[XLEN-1], E_ValB[XLEN-1], e_ValE[XLEN-1]);
            end
            4'h1: begin
              e_ValE = E_ValB - E_ValA;
              cc_ld  = !mul_hold;
              ovf    = sub_ovf(E_ValA[XLEN-1], E_ValB[XLEN-1], e_ValE[XLEN-1]);
            end
            4'h2: begin
              e_ValE = E_ValB & E_ValA;
              cc_ld  = !mul_hold;
            end
            4'h3: begin
              e_ValE = E_ValB ^ E_ValA;
              cc_ld  = !mul_hold;
            end
            default: e_ValE = '0;
          endcase
        end
        default:     e_ValE = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ZF <= 1'b1;
      SF <= 1'b0;
      OF <= 1'b0;
    end else if (cc_ld && !exc) begin
      ZF <= (e_ValE == '0);
      SF <= e_ValE[XLEN-1];
      OF <= ovf;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (E_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (SF ^ OF) | ZF;
      4'h2:    cond = SF ^ OF;
      4'h3:    cond = ZF;
      4'h4:    cond = ~ZF;
      4'h5:    cond = ~(SF ^ OF);
      4'h6:    cond = ~(SF ^ OF) & ~ZF;
      default: cond = 1'b0;
    endcase
    e_Cnd  = ((E_icode == 4'h2) || (E_icode == 4'h7)) ? cond : 1'b0;
    e_dstE = ((E_icode == 4'h2) && !e_Cnd) ? 4'hF : E_dstE;
  end

endmodule

// File: tb/tb_execute_cc_mul.sv
// Directed bench for execute_cc_mul: vector table for single-cycle ops plus hand sequences for mulq and reset.
module tb_execute_cc_mul;
  localparam int XLEN   = 64;
  localparam int STAT_W = 4;

  logic                   clk;
  logic                   rst_n;
  logic [3:0]             E_icode, E_ifun, E_dstE;
  logic signed [XLEN-1:0] E_ValA, E_ValB, E_ValC;
  logic [STAT_W-1:0]      m_stat, W_stat;
  logic signed [XLEN-1:0] e_ValE;
  logic                   e_Cnd;
  logic [3:0]             e_dstE;
  logic                   ZF, SF, OF, e_busy;

  int checks = 0;
  int errors = 0;

  execute_cc_mul #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .E_icode(E_icode), .E_ifun(E_ifun),
    .E_ValA(E_ValA), .E_ValB(E_ValB), .E_ValC(E_ValC),
    .E_dstE(E_dstE), .m_stat(m_stat), .W_stat(W_stat),
    .e_ValE(e_ValE), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
    .ZF(ZF), .SF(SF), .OF(OF), .e_busy(e_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      icode, ifun;
    logic [XLEN-1:0] a, b, c;
    logic [3:0]      dst;
    logic [3:0]      ms, ws;
    logic [XLEN-1:0] vale;
    logic            cnd;
    logic [3:0]      dste;
    logic            zf, sf, of;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [XLEN-1:0] c, input logic [3:0] dst,
                              input logic [3:0] ms, input logic [3:0] ws,
                              input logic [XLEN-1:0] vale, input logic cnd,
                              input logic [3:0] dste,
                              input logic zf, input logic sf, input logic of);
    vec_t v;
    v.icode = icode; v.ifun = ifun; v.a = a; v.b = b; v.c = c; v.dst = dst;
    v.ms = ms; v.ws = ws; v.vale = vale; v.cnd = cnd; v.dste = dste;
    v.zf = zf; v.sf = sf; v.of = of;
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] c, input logic [3:0] dst,
                       input logic [3:0] ms, input logic [3:0] ws);
    E_icode = icode; E_ifun = ifun; E_ValA = a; E_ValB = b; E_ValC = c;
    E_dstE = dst; m_stat = ms; W_stat = ws;
  endtask

  task automatic chk_flags(input string name, input logic zf, input logic sf, input logic of);
    chk({name, ".ZF"}, {63'd0, ZF}, {63'd0, zf});
    chk({name, ".SF"}, {63'd0, SF}, {63'd0, sf});
    chk({name, ".OF"}, {63'd0, OF}, {63'd0, of});
  endtask

  localparam logic [XLEN-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [XLEN-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int busy_cnt;
    rst_n = 1'b0;
    drive(4'h0, 4'h0, '0, '0, '0, 4'h0, 4'h1, 4'h1);

    //        icode ifun a      b      c     dst ms  ws   vale                   cnd dste zf sf of
    tv.push_back(mk(4'h7, 4'h1, 0,     0,     0,    3, 1, 1, 0,                    1, 3,   1, 0, 0));
    tv.push_back(mk(4'h6, 4'h1, 5,     5,     0,    3, 1, 1, 0,                    0, 3,   1, 0, 0));
    tv.push_back(mk(4'h2, 4'h4, 64'h11,0,     0,    5, 1, 1, 64'h11,               0, 4'hF,1, 0, 0));
    tv.push_back(mk(4'h6, 4'h0, MAXP,  MAXP,  0,    3, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 3, 0, 1, 1));
    tv.push_back(mk(4'h7, 4'h2, 0,     0,     0,    3, 1, 1, 0,                    0, 3,   0, 1, 1));
    tv.push_back(mk(4'h7, 4'h1, 0,     0,     0,    3, 1, 1, 0,                    0, 3,   0, 1, 1));
    tv.push_back(mk(4'h7, 4'h6, 0,     0,     0,    3, 1, 1, 0,                    1, 3,   0, 1, 1));
    tv.push_back(mk(4'h6, 4'h0, 1,     NEG1,  0,    3, 3, 1, 0,                    0, 3,   0, 1, 1));
    tv.push_back(mk(4'h6, 4'h0, 1,     NEG1,  0,    3, 1, 4, 0,                    0, 3,   0, 1, 1));
    tv.push_back(mk(4'h6, 4'h0, 1,     NEG1,  0,    3, 1, 2, 0,                    0, 3,   0, 1, 1));
    tv.push_back(mk(4'h2, 4'h0, 64'h1234, 0,  0,    7, 1, 1, 64'h1234,             1, 7,   0, 1, 1));
    tv.push_back(mk(4'h2, 4'h8, 64'h9,  0,    0,    7, 1, 1, 64'h9,                0, 4'hF,0, 1, 1));
    tv.push_back(mk(4'h3, 4'h0, 0,     0,     64'h55, 7, 1, 1, 64'h55,             0, 7,   0, 1, 1));
    tv.push_back(mk(4'h4, 4'h0, 0,     100,   8,    7, 1, 1, 108,                  0, 7,   0, 1, 1));
    tv.push_back(mk(4'h5, 4'h0, 0,     100,   8,    7, 1, 1, 108,                  0, 7,   0, 1, 1));
    tv.push_back(mk(4'h8, 4'h0, 0,     64'h40,0,    4, 1, 1, 64'h38,               0, 4,   0, 1, 1));
    tv.push_back(mk(4'h9, 4'h0, 0,     64'h40,0,    4, 1, 1, 64'h48,               0, 4,   0, 1, 1));
    tv.push_back(mk(4'hA, 4'h0, 0,     64'h40,0,    4, 1, 1, 64'h38,               0, 4,   0, 1, 1));
    tv.push_back(mk(4'hB, 4'h0, 0,     64'h40,0,    4, 1, 1, 64'h48,               0, 4,   0, 1, 1));
    tv.push_back(mk(4'h6, 4'h2, 64'hF0,64'h3C,0,    3, 1, 1, 64'h30,               0, 3,   0, 0, 0));
    tv.push_back(mk(4'h6, 4'h5, 1,     2,     0,    3, 1, 1, 0,                    0, 3,   0, 0, 0));
    tv.push_back(mk(4'h6, 4'h3, 64'hFF,64'hFF,0,    3, 1, 1, 0,                    0, 3,   1, 0, 0));
    tv.push_back(mk(4'h6, 4'h1, 1,     MINN,  0,    3, 1, 1, MAXP,                 0, 3,   0, 0, 1));
    tv.push_back(mk(4'h7, 4'h5, 0,     0,     0,    3, 1, 1, 0,                    0, 3,   0, 0, 1));
    tv.push_back(mk(4'h7, 4'h4, 0,     0,     0,    3, 1, 1, 0,                    1, 3,   0, 0, 1));
    tv.push_back(mk(4'h7, 4'h3, 0,     0,     0,    3, 1, 1, 0,                    0, 3,   0, 0, 1));
    tv.push_back(mk(4'h7, 4'h7, 0,     0,     0,    3, 1, 1, 0,                    0, 3,   0, 0, 1));
    tv.push_back(mk(4'h2, 4'h1, 64'h77,0,     0,    6, 1, 1, 64'h77,               1, 6,   0, 0, 1));
    tv.push_back(mk(4'h0, 4'h0, 9,     9,     9,    6, 1, 1, 0,                    0, 6,   0, 0, 1));
    tv.push_back(mk(4'h1, 4'h0, 9,     9,     9,    6, 1, 1, 0,                    0, 6,   0, 0, 1));

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset", 1'b1, 1'b0, 1'b0);
    chk("reset.busy", {63'd0, e_busy}, 64'd0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].icode, tv[i].ifun, tv[i].a, tv[i].b, tv[i].c, tv[i].dst, tv[i].ms, tv[i].ws);
      @(negedge clk);
      chk($sformatf("v%0d.ValE", i), e_ValE, tv[i].vale);
      chk($sformatf("v%0d.Cnd", i), {63'd0, e_Cnd}, {63'd0, tv[i].cnd});
      chk($sformatf("v%0d.dstE", i), {60'd0, e_dstE}, {60'd0, tv[i].dste});
      chk($sformatf("v%0d.busy", i), {63'd0, e_busy}, 64'd0);
      @(posedge clk);
      #1;
      chk_flags($sformatf("v%0d", i), tv[i].zf, tv[i].sf, tv[i].of);
    end
    // Flags now ZF=0 SF=0 OF=1

`ifdef EXECUTE_MULQ_EN
    // mulq -3 * 7: busy from issue through the last MUL cycle, result in the cycle after
    drive(4'h6, 4'h4, -64'sd3, 64'sd7, 0, 3, 1, 1);
    busy_cnt = 0;
    @(negedge clk);
    while (e_busy === 1'b1 && busy_cnt < 200) begin
      busy_cnt++;
      if (busy_cnt == 3) E_ValA = 64'sd5;
      @(negedge clk);
    end
    chk("mul.busy_cycles", busy_cnt, 65);
    chk("mul.ValE", e_ValE, -64'sd21);
    chk("mul.busy_done", {63'd0, e_busy}, 64'd0);
    @(posedge clk);
    #1;
    drive(4'h0, 4'h0, 0, 0, 0, 3, 1, 1);
    chk_flags("mul", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mul.idle_busy", {63'd0, e_busy}, 64'd0);
    @(posedge clk);
    #1;

    // Abort a multiply with reset in cycle t+10
    drive(4'h6, 4'h4, 64'sd6, 64'sd6, 0, 3, 1, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort.busy_before", {63'd0, e_busy}, 64'd1);
`else
    // Without the multiplier, mulq is an invalid OPq
    drive(4'h6, 4'h4, -64'sd3, 64'sd7, 0, 3, 1, 1);
    @(negedge clk);
    chk("mulq_off.ValE", e_ValE, 64'd0);
    chk("mulq_off.busy", {63'd0, e_busy}, 64'd0);
    @(posedge clk);
    #1;
    chk_flags("mulq_off", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("mulq_off.busy2", {63'd0, e_busy}, 64'd0);
    @(posedge clk);
    #1;
`endif
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 0, 0, 0, 3, 1, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst.busy", {63'd0, e_busy}, 64'd0);
    chk_flags("rst", 1'b1, 1'b0, 1'b0);
    drive(4'h6, 4'h0, 64'sd2, 64'sd3, 0, 3, 1, 1);
    @(negedge clk);
    chk("post_rst.ValE", e_ValE, 64'd5);
    chk("post_rst.busy", {63'd0, e_busy}, 64'd0);
    @(posedge clk);
    #1;
    chk_flags("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst.busy2", {63'd0, e_busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
